// File: rtl/ara_test_harness_pkg.sv
// Shared types and helpers for the ARA self-checking harness:
// FSM states, the golden data pattern and data-width helpers.
package ara_test_harness_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        DONE
    } state_e;

    localparam logic [63:0] GoldenMul  = 64'h9E3779B97F4A7C15;
    localparam int          SliceWidth = 64;

    function automatic int slices_per_word(int width);
        return width / SliceWidth;
    endfunction

    // 64-bit slice of a wide word; the multiply wraps at 64 bits.
    function automatic logic [63:0] pattern(logic [63:0] word_idx, logic [63:0] slice_idx);
        return (word_idx * GoldenMul) ^ slice_idx;
    endfunction

endpackage

// File: rtl/ara_test_harness_if.sv
// Word-addressed single-port memory bus between the traffic engine and one bank.
interface ara_test_harness_if #(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64
);
    logic                 we;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic [DataWidth-1:0] rdata;

    modport master (output we, addr, wdata, input rdata);
    modport slave  (input we, addr, wdata, output rdata);
endinterface

// File: rtl/ara_test_harness_bank.sv
// Single-port SRAM model for one cluster: synchronous write, registered read.
module ara_test_harness_bank #(
    parameter int Width     = 64,
    parameter int Depth     = 16,
    parameter int AddrWidth = 64
) (
    input logic                clk_i,
    ara_test_harness_if.slave  bus
);
    localparam int IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0]    mem [Depth];
    logic [IdxWidth-1:0] idx;
    logic                in_range;

    // Addresses past the end of the array are ignored rather than aliased.
    assign in_range = bus.addr < AddrWidth'(Depth);
    assign idx      = bus.addr[IdxWidth-1:0];

    // NOTE: the array is deliberately not reset; every word is rewritten before it is read.
    always_ff @(posedge clk_i) begin
        if (bus.we && in_range) begin
            mem[idx] <= bus.wdata;
        end
        if (!bus.we && in_range) begin
            bus.rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/ara_test_harness.sv
// Self-checking harness: writes a golden pattern into banked memory, reads it back,
// counts mismatching words and cycles, and reports a tohost-style exit word.
module ara_test_harness
    import ara_test_harness_pkg::*;
#(
    parameter int NrLanes             = 4,
    parameter int NrClusters          = 1,
    parameter int AxiAddrWidth        = 64,
    parameter int AxiDataWidth        = 64 * NrLanes / 2,
    parameter int ClusterAxiDataWidth = AxiDataWidth / NrClusters,
    parameter int NumWords            = 16,
    parameter int InjectErrWord       = -1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [63:0] exit_o
);
    localparam int NrSlices = slices_per_word(AxiDataWidth);
    localparam int IdxWidth = $clog2(NumWords + 1);

    if (NrClusters * ClusterAxiDataWidth != AxiDataWidth) begin : g_chk_split
        $error("cluster slices do not tile the wide word");
    end
    if (AxiDataWidth % 64 != 0 || ClusterAxiDataWidth % 64 != 0) begin : g_chk_width
        $error("data widths must be multiples of 64");
    end
    if (InjectErrWord >= NumWords || NumWords < 2) begin : g_chk_words
        $error("bad NumWords / InjectErrWord");
    end
    if (NrLanes < 2 || (NrLanes & (NrLanes - 1)) != 0) begin : g_chk_lanes
        $error("NrLanes must be a power of two >= 2");
    end

    state_e                  state_q, state_d;
    logic [IdxWidth-1:0]     idx_q, idx_d;
    logic [IdxWidth-1:0]     rd_idx_q;
    logic                    rd_valid_q;
    logic                    issue;
    logic                    mismatch;
    logic [62:0]             err_cnt_q, err_cnt_d;
    logic [63:0]             runtime_buf_q;
    logic [63:0]             exit_q;
    logic                    mem_we;
    logic [AxiAddrWidth-1:0] mem_addr;
    logic [AxiDataWidth-1:0] wdata, golden_rd, rdata;

    always_comb begin
        wdata     = '0;
        golden_rd = '0;
        for (int k = 0; k < NrSlices; k++) begin
            wdata[k*64 +: 64]     = pattern(64'(idx_q), 64'(k));
            golden_rd[k*64 +: 64] = pattern(64'(rd_idx_q), 64'(k));
        end
        // Corruption goes to memory only; the readback reference stays clean.
        if (InjectErrWord >= 0 && int'(idx_q) == InjectErrWord) begin
            wdata[0] = ~wdata[0];
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mem_we  = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = WRITE;
                idx_d   = '0;
            end
            WRITE: begin
                mem_we = 1'b1;
                if (idx_q == IdxWidth'(NumWords - 1)) begin
                    state_d = READ;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IdxWidth'(1);
                end
            end
            READ: begin
                issue = (idx_q != IdxWidth'(NumWords));
                if (issue) begin
                    idx_d = idx_q + IdxWidth'(1);
                end
                // Leave only once the last word's data has come back and been compared.
                if (rd_valid_q && rd_idx_q == IdxWidth'(NumWords - 1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_addr  = AxiAddrWidth'(idx_q);
    assign mismatch  = rd_valid_q && (rdata != golden_rd);
    assign err_cnt_d = (mismatch && err_cnt_q != '1) ? err_cnt_q + 63'd1 : err_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            rd_idx_q      <= '0;
            rd_valid_q    <= 1'b0;
            err_cnt_q     <= '0;
            runtime_buf_q <= '0;
            exit_q        <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rd_idx_q   <= idx_q;
            rd_valid_q <= issue;
            err_cnt_q  <= err_cnt_d;
            if (state_q == WRITE || state_q == READ) begin
                runtime_buf_q <= runtime_buf_q + 64'd1;
            end
            if (state_q != DONE && state_d == DONE) begin
                exit_q <= {err_cnt_d, 1'b1};
            end
        end
    end

    assign exit_o = exit_q;

    for (genvar c = 0; c < NrClusters; c++) begin : g_bank
        ara_test_harness_if #(
            .AddrWidth (AxiAddrWidth),
            .DataWidth (ClusterAxiDataWidth)
        ) bus ();

        assign bus.we    = mem_we;
        assign bus.addr  = mem_addr;
        assign bus.wdata = wdata[c*ClusterAxiDataWidth +: ClusterAxiDataWidth];
        assign rdata[c*ClusterAxiDataWidth +: ClusterAxiDataWidth] = bus.rdata;

        ara_test_harness_bank #(
            .Width     (ClusterAxiDataWidth),
            .Depth     (NumWords),
            .AddrWidth (AxiAddrWidth)
        ) u_bank (
            .clk_i (clk_i),
            .bus   (bus)
        );
    end

endmodule

// File: tb/tb_ara_test_harness.sv
// Bench for ara_test_harness: several parameterisations run side by side against a
// cycle-level reference of the run timeline, plus randomized mid-run resets.
module tb_ara_test_harness;

    localparam int NDef  = 16;
    localparam int NWide = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rst_def;
    logic [63:0] exit_def, exit_e5, exit_e0, exit_e15, exit_wide;

    int n_checks = 0;
    int n_errors = 0;

    ara_test_harness u_def (
        .clk_i (clk), .rst_i (rst_def), .exit_o (exit_def)
    );
    ara_test_harness #(.InjectErrWord (5)) u_e5 (
        .clk_i (clk), .rst_i (rst), .exit_o (exit_e5)
    );
    ara_test_harness #(.InjectErrWord (0)) u_e0 (
        .clk_i (clk), .rst_i (rst), .exit_o (exit_e0)
    );
    ara_test_harness #(.InjectErrWord (15)) u_e15 (
        .clk_i (clk), .rst_i (rst), .exit_o (exit_e15)
    );
    ara_test_harness #(
        .NrLanes (8), .NrClusters (2), .ClusterAxiDataWidth (128), .NumWords (NWide)
    ) u_wide (
        .clk_i (clk), .rst_i (rst), .exit_o (exit_wide)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_pattern(int w, int k);
        logic [63:0] p;
        p = 64'(w) * 64'h9E3779B97F4A7C15;
        return p ^ 64'(k);
    endfunction

    // Timeline after reset release: 1 IDLE, n WRITE, n+1 READ cycles, then DONE.
    function automatic logic [63:0] exp_exit(int n, int errs, int c);
        return (c >= 2 * n + 2) ? {63'(errs), 1'b1} : 64'd0;
    endfunction

    function automatic logic [63:0] exp_runtime(int n, int c);
        if (c <= 1) return 64'd0;
        if (c - 1 > 2 * n + 1) return 64'(2 * n + 1);
        return 64'(c - 1);
    endfunction

    task automatic run_def(input int cycles, input string tag);
        for (int c = 1; c <= cycles; c++) begin
            @(posedge clk); #1;
            check({tag, "_exit"}, exit_def, exp_exit(NDef, 0, c));
            check({tag, "_runtime"}, u_def.runtime_buf_q, exp_runtime(NDef, c));
        end
    endtask

    initial begin
        int cut;
        int hold;
        rst     = 1'b1;
        rst_def = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_exit", exit_def, 64'd0);
        check("reset_runtime", u_def.runtime_buf_q, 64'd0);
        rst     = 1'b0;
        rst_def = 1'b0;

        // All configurations in parallel; the tail keeps everyone in DONE for >100 cycles.
        for (int c = 1; c <= 2 * NWide + 2 + 100; c++) begin
            @(posedge clk); #1;
            check("def_exit", exit_def, exp_exit(NDef, 0, c));
            check("def_runtime", u_def.runtime_buf_q, exp_runtime(NDef, c));
            check("e5_exit", exit_e5, exp_exit(NDef, 1, c));
            check("e5_runtime", u_e5.runtime_buf_q, exp_runtime(NDef, c));
            check("e0_exit", exit_e0, exp_exit(NDef, 1, c));
            check("e15_exit", exit_e15, exp_exit(NDef, 1, c));
            check("wide_exit", exit_wide, exp_exit(NWide, 0, c));
            check("wide_runtime", u_wide.runtime_buf_q, exp_runtime(NWide, c));
        end

        for (int i = 0; i < NWide; i++) begin
            for (int h = 0; h < 2; h++) begin
                check("wide_bank0", u_wide.g_bank[0].u_bank.mem[i][h*64 +: 64], ref_pattern(i, h));
                check("wide_bank1", u_wide.g_bank[1].u_bank.mem[i][h*64 +: 64], ref_pattern(i, 2 + h));
            end
        end
        check("e0_stored_word0", u_e0.g_bank[0].u_bank.mem[0][63:0], ref_pattern(0, 0) ^ 64'd1);
        check("e0_stored_word1", u_e0.g_bank[0].u_bank.mem[1][63:0], ref_pattern(1, 0));

        // Asynchronous resets mid-run: the first at cycle 20 (READ) for 3 cycles, then random.
        for (int run = 0; run < 4; run++) begin
            cut  = (run == 0) ? 20 : int'($urandom_range(1, 2 * NDef + 1));
            hold = (run == 0) ? 3 : int'($urandom_range(1, 5));
            @(negedge clk); rst_def = 1'b1;
            @(negedge clk); rst_def = 1'b0;
            run_def(cut, "pre_cut");
            #2 rst_def = 1'b1;
            #1;
            check("midreset_exit", exit_def, 64'd0);
            check("midreset_runtime", u_def.runtime_buf_q, 64'd0);
            repeat (hold) @(posedge clk);
            @(negedge clk); rst_def = 1'b0;
            run_def(2 * NDef + 12, "rerun");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
